// File: rtl/line_sensor_pkg.sv
// Shared constants and types for the three-channel line sensor front end.
// Channel bit positions match the motor controller's {left, middle, right} vector.
package line_sensor_pkg;

  localparam int SENS_LEFT    = 2;
  localparam int SENS_MIDDLE  = 1;
  localparam int SENS_RIGHT   = 0;
  localparam int SENSOR_COUNT = 3;

  typedef logic [SENSOR_COUNT-1:0] sensorVec_t;

  localparam int PRESCALE_DEF   = 1000;
  localparam int INT_WIDTH_DEF  = 4;
  localparam int ON_THRESH_DEF  = 12;
  localparam int OFF_THRESH_DEF = 3;

endpackage

// File: rtl/sensor_integrator.sv
// One sensor channel: 2-flop synchroniser, saturating tick integrator, hysteresis output.
// LINE_SENSOR_INVERT_EN inverts the raw bit ahead of the synchroniser (boards reading 1 on black).
module sensor_integrator
  import line_sensor_pkg::*;
#(
  parameter int INT_WIDTH  = INT_WIDTH_DEF,
  parameter int ON_THRESH  = ON_THRESH_DEF,
  parameter int OFF_THRESH = OFF_THRESH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic tick,
  output logic filtered,
  output logic filteredNext
);

  localparam logic [INT_WIDTH-1:0] INT_MAX_V = {INT_WIDTH{1'b1}};
  localparam logic [INT_WIDTH-1:0] ZERO_V    = {INT_WIDTH{1'b0}};
  localparam logic [INT_WIDTH-1:0] ONE_V     = {{(INT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [INT_WIDTH-1:0] ON_V      = INT_WIDTH'(ON_THRESH);
  localparam logic [INT_WIDTH-1:0] OFF_V     = INT_WIDTH'(OFF_THRESH);

  logic                 rawIn_s;
  logic                 sync1_r;
  logic                 sync2_r;
  logic [INT_WIDTH-1:0] integ_r;
  logic [INT_WIDTH-1:0] integNext_s;
  logic                 filtered_r;
  logic                 filtNext_s;

`ifdef LINE_SENSOR_INVERT_EN
  assign rawIn_s = ~raw;
`else
  assign rawIn_s = raw;
`endif

  // Saturating step toward the synced level; never wraps.
  always_comb begin
    integNext_s = integ_r;
    if (sync2_r) begin
      if (integ_r != INT_MAX_V) begin
        integNext_s = integ_r + ONE_V;
      end else begin
        integNext_s = integ_r;
      end
    end else begin
      if (integ_r != ZERO_V) begin
        integNext_s = integ_r - ONE_V;
      end else begin
        integNext_s = integ_r;
      end
    end
  end

  always_comb begin
    filtNext_s = filtered_r;
    if (integNext_s >= ON_V) begin
      filtNext_s = 1'b1;
    end else if (integNext_s <= OFF_V) begin
      filtNext_s = 1'b0;
    end else begin
      filtNext_s = filtered_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rawIn_s;
      sync2_r <= sync1_r;
    end
  end

  // Integrator and output only move on a sample tick; reset parks them on the safe rail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      integ_r    <= INT_MAX_V;
      filtered_r <= 1'b1;
    end else if (tick) begin
      integ_r    <= integNext_s;
      filtered_r <= filtNext_s;
    end else begin
      integ_r    <= integ_r;
      filtered_r <= filtered_r;
    end
  end

  assign filtered     = filtered_r;
  assign filteredNext = filtNext_s;

endmodule

// File: rtl/line_sensor_filter.sv
// Line sensor front end: shared sample prescaler, three filtered channels, change pulse.
// Build option LINE_SENSOR_INVERT_EN inverts every raw input (see sensor_integrator).
module line_sensor_filter
  import line_sensor_pkg::*;
#(
  parameter int PRESCALE   = PRESCALE_DEF,
  parameter int INT_WIDTH  = INT_WIDTH_DEF,
  parameter int ON_THRESH  = ON_THRESH_DEF,
  parameter int OFF_THRESH = OFF_THRESH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sensorLeftRaw,
  input  logic sensorMiddleRaw,
  input  logic sensorRightRaw,
  output logic sensorLeftFiltered,
  output logic sensorMiddleFiltered,
  output logic sensorRightFiltered,
  output logic sample_tick,
  output logic changed
);

  localparam int CNT_W = (PRESCALE < 2) ? 1 : $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] TERM_V  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

  if ((OFF_THRESH < 0) || (OFF_THRESH >= ON_THRESH) ||
      (ON_THRESH > ((2 ** INT_WIDTH) - 1)) || (PRESCALE < 2)) begin : gBadParams
    $fatal(1, "line_sensor_filter: illegal PRESCALE/threshold parameters");
  end

  logic [CNT_W-1:0] count_r;
  logic             termTick_s;
  logic             sampleTick_r;
  logic             changed_r;
  sensorVec_t       rawVec_s;
  sensorVec_t       filtVec_s;
  sensorVec_t       filtNext_s;

  assign rawVec_s[SENS_LEFT]   = sensorLeftRaw;
  assign rawVec_s[SENS_MIDDLE] = sensorMiddleRaw;
  assign rawVec_s[SENS_RIGHT]  = sensorRightRaw;

  assign termTick_s = (count_r == TERM_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= ZERO_C;
    end else if (termTick_s) begin
      count_r <= ZERO_C;
    end else begin
      count_r <= count_r + ONE_C;
    end
  end

  // Pulses are registered on the terminal-count edge, alongside the filtered vector update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sampleTick_r <= 1'b0;
      changed_r    <= 1'b0;
    end else begin
      sampleTick_r <= termTick_s;
      changed_r    <= termTick_s && (filtNext_s != filtVec_s);
    end
  end

  for (genvar i = 0; i < SENSOR_COUNT; i++) begin : gChan
    sensor_integrator #(
      .INT_WIDTH (INT_WIDTH),
      .ON_THRESH (ON_THRESH),
      .OFF_THRESH(OFF_THRESH)
    ) uChan (
      .clk         (clk),
      .rst         (rst),
      .raw         (rawVec_s[i]),
      .tick        (termTick_s),
      .filtered    (filtVec_s[i]),
      .filteredNext(filtNext_s[i])
    );
  end

  assign sensorLeftFiltered   = filtVec_s[SENS_LEFT];
  assign sensorMiddleFiltered = filtVec_s[SENS_MIDDLE];
  assign sensorRightFiltered  = filtVec_s[SENS_RIGHT];
  assign sample_tick          = sampleTick_r;
  assign changed              = changed_r;

endmodule

// File: tb/tb_line_sensor_filter.sv
// Self-checking bench for line_sensor_filter (PRESCALE=4, INT_WIDTH=4, ON=12, OFF=3).
// Phase table plus hand sequences and random raw activity, all checked against a tick-level model.
module tb_line_sensor_filter;

  localparam int PRESCALE = 4;
  localparam int INT_MAX  = 15;
  localparam int ON       = 12;
  localparam int OFF      = 3;
`ifdef LINE_SENSOR_INVERT_EN
  localparam logic [2:0] INV = 3'b111;
`else
  localparam logic [2:0] INV = 3'b000;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [2:0] rawPhys;
  logic fL, fM, fR, sampleTick, changed;

  always #5 clk = ~clk;

  line_sensor_filter #(.PRESCALE(PRESCALE), .INT_WIDTH(4), .ON_THRESH(ON), .OFF_THRESH(OFF)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .sensorLeftRaw       (rawPhys[2]),
    .sensorMiddleRaw     (rawPhys[1]),
    .sensorRightRaw      (rawPhys[0]),
    .sensorLeftFiltered  (fL),
    .sensorMiddleFiltered(fM),
    .sensorRightFiltered (fR),
    .sample_tick         (sampleTick),
    .changed             (changed)
  );

  // Reference model: every PRESCALE-th edge after release, each channel steps its
  // integrator toward the level seen two edges earlier, and hysteresis sets the output.
  int         mInteg [3];
  logic [2:0] mFilt, mHA, mHB;
  logic       mTick, mChanged;
  int         mEdges;

  function automatic int satStep(int v, logic s);
    if (s) return (v < INT_MAX) ? v + 1 : INT_MAX;
    else   return (v > 0) ? v - 1 : 0;
  endfunction

  function automatic logic hyst(logic old, int v);
    if (v >= ON)       return 1'b1;
    else if (v <= OFF) return 1'b0;
    else               return old;
  endfunction

  function automatic logic [2:0] tickVec(logic [2:0] filt, logic [2:0] s, int i2, int i1, int i0);
    return {hyst(filt[2], satStep(i2, s[2])), hyst(filt[1], satStep(i1, s[1])),
            hyst(filt[0], satStep(i0, s[0]))};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mHA <= 3'b111; mHB <= 3'b111; mFilt <= 3'b111;
      mEdges <= 0; mTick <= 1'b0; mChanged <= 1'b0;
      for (int i = 0; i < 3; i++) mInteg[i] <= INT_MAX;
    end else begin
      mEdges <= mEdges + 1;
      mHA    <= rawPhys ^ INV;
      mHB    <= mHA;
      if (((mEdges + 1) % PRESCALE) == 0) begin
        for (int i = 0; i < 3; i++) mInteg[i] <= satStep(mInteg[i], mHB[i]);
        mFilt    <= tickVec(mFilt, mHB, mInteg[2], mInteg[1], mInteg[0]);
        mChanged <= (tickVec(mFilt, mHB, mInteg[2], mInteg[1], mInteg[0]) != mFilt);
        mTick    <= 1'b1;
      end else begin
        mTick    <= 1'b0;
        mChanged <= 1'b0;
      end
    end
  end

  int tests = 0;
  int fails = 0;
  int chgSeen = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock, then compare every output against the model on the falling edge.
  task automatic cycle();
    @(negedge clk);
    check("cycle_vs_model", {fL, fM, fR, sampleTick, changed}, {mFilt, mTick, mChanged});
    if (changed) chgSeen++;
  endtask

  task automatic setRaw(input logic [2:0] logicalLevel);
    rawPhys = logicalLevel ^ INV;
  endtask

  task automatic firstTick(output int n);
    n = -1;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      if (sampleTick) begin
        n = c;
        break;
      end
    end
  endtask

  typedef struct {
    logic [2:0] raw;
    int         ticks;
    logic [2:0] expVec;
    int         expChg;
  } phase_t;

  phase_t tbl [9];
  int     n;

  initial begin
    tbl[0] = '{3'b011, 12, 3'b011, 1};  // left step: falls on 12th tick
    tbl[1] = '{3'b111, 12, 3'b111, 1};  // left recovers
    tbl[2] = '{3'b101,  5, 3'b111, 0};  // middle glitch, integrator 10
    tbl[3] = '{3'b111,  5, 3'b111, 0};
    tbl[4] = '{3'b110, 40, 3'b110, 1};  // right pinned at 0
    tbl[5] = '{3'b111, 11, 3'b110, 0};  // integrator 11, still low
    tbl[6] = '{3'b111,  1, 3'b111, 1};  // 12th tick: rises
    tbl[7] = '{3'b111,  3, 3'b111, 0};
    tbl[8] = '{3'b010, 12, 3'b010, 1};  // left+right together, one pulse

    rst = 1'b1;
    setRaw(3'b111);
    repeat (3) cycle();
    check("reset_vec", {fL, fM, fR}, 3'b111);
    check("reset_pulses", {sampleTick, changed}, 2'b00);

    rst = 1'b0;
    chgSeen = 0;
    firstTick(n);
    check("first_tick_latency", n, 4);
    repeat (3 * PRESCALE) cycle();
    check("idle_changes", chgSeen, 0);

    for (int i = 0; i < 9; i++) begin
      setRaw(tbl[i].raw);
      chgSeen = 0;
      repeat (tbl[i].ticks * PRESCALE) cycle();
      check("phase_vec", {fL, fM, fR}, tbl[i].expVec);
      check("phase_changes", chgSeen, tbl[i].expChg);
    end

    // Asynchronous reset in the middle of a prescale period.
    setRaw(3'b111);
    repeat (2) cycle();
    #2 rst = 1'b1;
    #1;
    check("async_rst_vec", {fL, fM, fR}, 3'b111);
    check("async_rst_pulses", {sampleTick, changed}, 2'b00);
    cycle();
    rst = 1'b0;
    firstTick(n);
    check("restart_tick_latency", n, 4);

    // Random raw levels with random hold times, including off-tick changes.
    for (int k = 0; k < 16; k++) begin
      rawPhys = 3'($urandom_range(0, 7));
      repeat ($urandom_range(4, 60)) cycle();
    end

    // Physical all-ones: reads as black only when the inversion option is built in.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    rawPhys = 3'b111;
    repeat (12 * PRESCALE) cycle();
`ifdef LINE_SENSOR_INVERT_EN
    check("invert_vec", {fL, fM, fR}, 3'b000);
`else
    check("invert_vec", {fL, fM, fR}, 3'b111);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
